// File: rtl/ov_chain_ctrl.sv
// Overflow-flag write arbiter and multi-word chain sequencer.
// Arbitrates ALU and software flag writes against chained carry operations that route the flag through the ALU carry.
module ov_chain_ctrl (
    input  logic       CLK,
    input  logic       reset,
    input  logic       alu_req,
    input  logic       alu_ov,
    input  logic       sw_req,
    input  logic       sw_val,
    input  logic       chain_start,
    input  logic [2:0] chain_len,
    input  logic       chain_carry,
    input  logic       ovOut,
    output logic       OvWrite,
    output logic       dataIn,
    output logic       carry_in,
    output logic       step,
    output logic [2:0] step_idx,
    output logic [1:0] grant,
    output logic       alu_stall,
    output logic       sw_stall,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] GRANT_NONE  = 2'b00;
    localparam logic [1:0] GRANT_ALU   = 2'b01;
    localparam logic [1:0] GRANT_SW    = 2'b10;
    localparam logic [1:0] GRANT_CHAIN = 2'b11;
    localparam logic [2:0] IDX_MAX     = 3'd7;

    state_t     state_reg, state_next;
    logic [2:0] len_reg, len_next;
    logic [2:0] idx_reg, idx_next;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            len_reg   <= 3'd0;
            idx_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            idx_reg   <= idx_next;
        end
    end

    assign step_idx = idx_reg;

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        OvWrite    = 1'b0;
        dataIn     = 1'b0;
        carry_in   = 1'b0;
        step       = 1'b0;
        grant      = GRANT_NONE;
        alu_stall  = 1'b0;
        sw_stall   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (chain_start) begin
                    // The flag write for this cycle is suppressed; CLEAR writes 0 next.
                    grant      = GRANT_CHAIN;
                    len_next   = chain_len;
                    state_next = CLEAR;
                    sw_stall   = sw_req;
                    alu_stall  = alu_req;
                end else if (sw_req) begin
                    OvWrite   = 1'b1;
                    dataIn    = sw_val;
                    grant     = GRANT_SW;
                    alu_stall = alu_req;
                end else if (alu_req) begin
                    OvWrite = 1'b1;
                    dataIn  = alu_ov;
                    grant   = GRANT_ALU;
                end
            end
            CLEAR: begin
                busy       = 1'b1;
                grant      = GRANT_CHAIN;
                sw_stall   = sw_req;
                alu_stall  = alu_req;
                OvWrite    = 1'b1;
                dataIn     = 1'b0;
                idx_next   = 3'd0;
                state_next = STEP;
            end
            STEP: begin
                busy      = 1'b1;
                grant     = GRANT_CHAIN;
                sw_stall  = sw_req;
                alu_stall = alu_req;
                step      = 1'b1;
                // The flag register doubles as the inter-word carry latch.
                carry_in  = ovOut;
                OvWrite   = 1'b1;
                dataIn    = chain_carry;
                if (idx_reg == len_reg) begin
                    state_next = DONE;
                end else if (idx_reg != IDX_MAX) begin
                    idx_next = idx_reg + 3'd1;
                end
            end
            DONE: begin
                busy       = 1'b1;
                grant      = GRANT_CHAIN;
                sw_stall   = sw_req;
                alu_stall  = alu_req;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs drop the instant reset rises, not at the next edge.
        if (reset) begin
            OvWrite   = 1'b0;
            dataIn    = 1'b0;
            carry_in  = 1'b0;
            step      = 1'b0;
            grant     = GRANT_NONE;
            alu_stall = 1'b0;
            sw_stall  = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
        end
    end

endmodule

// File: tb/tb_ov_chain_ctrl.sv
// Directed self-checking bench for ov_chain_ctrl with a behavioural overflow register.
module tb_ov_chain_ctrl;

    logic       CLK = 1'b0;
    logic       reset;
    logic       alu_req, alu_ov, sw_req, sw_val, chain_start, chain_carry;
    logic [2:0] chain_len;
    logic       ovOut;
    logic       OvWrite, dataIn, carry_in, step, alu_stall, sw_stall, busy, done;
    logic [2:0] step_idx;
    logic [1:0] grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    // Overflow register driven by the DUT's write port.
    always @(posedge CLK or posedge reset) begin
        if (reset) ovOut <= 1'b0;
        else if (OvWrite) ovOut <= dataIn;
    end

    ov_chain_ctrl dut (
        .CLK(CLK), .reset(reset), .alu_req(alu_req), .alu_ov(alu_ov),
        .sw_req(sw_req), .sw_val(sw_val), .chain_start(chain_start),
        .chain_len(chain_len), .chain_carry(chain_carry), .ovOut(ovOut),
        .OvWrite(OvWrite), .dataIn(dataIn), .carry_in(carry_in), .step(step),
        .step_idx(step_idx), .grant(grant), .alu_stall(alu_stall),
        .sw_stall(sw_stall), .busy(busy), .done(done)
    );

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic clear_inputs();
        alu_req = 0; alu_ov = 0; sw_req = 0; sw_val = 0;
        chain_start = 0; chain_len = 0; chain_carry = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; alu_req = 1; alu_ov = 1; sw_req = 1; sw_val = 1; chain_start = 1;
        next_cycle(); next_cycle();
        settle();
        n_checks++;
        if ({OvWrite, dataIn, grant, alu_stall, sw_stall, busy, done, step, carry_in} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0", {OvWrite, dataIn, grant, alu_stall, sw_stall, busy, done, step, carry_in});
        end
        n_checks++;
        if (step_idx !== 3'd0) begin n_fail++; $display("FAIL reset_step_idx: got %0d required 0", step_idx); end
        next_cycle();
        clear_inputs();
        reset = 0;
        $display("reset: outputs held low while reset asserted");
    endtask

    task automatic test_alu_write();
        alu_req = 1; alu_ov = 1;
        settle();
        n_checks++;
        if ({OvWrite, dataIn, grant, alu_stall} !== 5'b11_01_0) begin
            n_fail++; $display("FAIL alu_write: got ow/di/gr/st %b required 11010", {OvWrite, dataIn, grant, alu_stall});
        end
        next_cycle();
        clear_inputs();
        settle();
        n_checks++;
        if (ovOut !== 1'b1) begin n_fail++; $display("FAIL alu_ov_stored: got %b required 1", ovOut); end
        n_checks++;
        if ({OvWrite, grant} !== 3'b0_00) begin n_fail++; $display("FAIL idle_quiet: got %b required 000", {OvWrite, grant}); end
        next_cycle();
        $display("alu_write: ovOut=%b", ovOut);
    endtask

    task automatic test_priority();
        alu_req = 1; alu_ov = 1; sw_req = 1; sw_val = 0;
        settle();
        n_checks++;
        if ({OvWrite, dataIn, grant, alu_stall, sw_stall} !== 6'b1_0_10_1_0) begin
            n_fail++; $display("FAIL sw_over_alu: got %b required 101010", {OvWrite, dataIn, grant, alu_stall, sw_stall});
        end
        next_cycle();
        clear_inputs();
        settle();
        n_checks++;
        if (ovOut !== 1'b0) begin n_fail++; $display("FAIL sw_val_stored: got %b required 0", ovOut); end
        next_cycle();
        $display("priority: sw beat alu, ovOut=%b", ovOut);
    endtask

    task automatic test_chain_len2();
        int busy_cnt = 0;
        logic [2:0] carries = 3'b101;     // step0..2 -> 1,0,1
        logic [2:0] exp_cin = 3'b010;     // step0..2 -> 0,1,0
        chain_start = 1; chain_len = 3'd2; sw_req = 1; sw_val = 1; alu_req = 1;
        settle();
        n_checks++;
        if ({OvWrite, grant, sw_stall, alu_stall, busy} !== 6'b0_11_1_1_0) begin
            n_fail++; $display("FAIL chain_start_cycle: got %b required 011110", {OvWrite, grant, sw_stall, alu_stall, busy});
        end
        next_cycle();
        clear_inputs();
        settle();
        if (busy) busy_cnt++;
        n_checks++;
        if ({busy, OvWrite, dataIn, step, carry_in} !== 5'b1_1_0_0_0) begin
            n_fail++; $display("FAIL clear_cycle: got %b required 11000", {busy, OvWrite, dataIn, step, carry_in});
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chain_carry = carries[i];
            settle();
            if (busy) busy_cnt++;
            n_checks++;
            if ({step, step_idx, carry_in, OvWrite, dataIn} !== {1'b1, 3'(i), exp_cin[i], 1'b1, carries[i]}) begin
                n_fail++;
                $display("FAIL chain_step%0d: got step=%b idx=%0d cin=%b ow=%b di=%b required 1 %0d %b 1 %b",
                         i, step, step_idx, carry_in, OvWrite, dataIn, i, exp_cin[i], carries[i]);
            end
        end
        next_cycle();
        clear_inputs();
        settle();
        if (busy) busy_cnt++;
        n_checks++;
        if ({done, OvWrite, step, step_idx} !== {1'b1, 1'b0, 1'b0, 3'd2}) begin
            n_fail++; $display("FAIL chain_done: got done=%b ow=%b step=%b idx=%0d required 1 0 0 2", done, OvWrite, step, step_idx);
        end
        next_cycle();
        settle();
        if (busy) busy_cnt++;
        n_checks++;
        if (done !== 1'b0 || busy_cnt != 5) begin
            n_fail++; $display("FAIL chain_busy_len: got done=%b busy_cycles=%0d required 0 5", done, busy_cnt);
        end
        n_checks++;
        if (step_idx !== 3'd2) begin n_fail++; $display("FAIL idx_hold: got %0d required 2", step_idx); end
        next_cycle();
        $display("chain_len2: busy_cycles=%0d ovOut=%b", busy_cnt, ovOut);
    endtask

    // Starts a chain and checks done latency, step count and final index.
    task automatic run_chain(input logic [2:0] len, input string name);
        int steps = 0;
        int k = 0;
        logic seen = 0;
        chain_start = 1; chain_len = len;
        next_cycle();
        clear_inputs();
        for (k = 1; k <= 12; k++) begin
            settle();
            if (step) steps++;
            if (done) begin seen = 1; break; end
            next_cycle();
        end
        n_checks++;
        if (!seen || k != int'(len) + 3 || steps != int'(len) + 1 || step_idx !== len) begin
            n_fail++;
            $display("FAIL %s: got done_seen=%b latency=%0d steps=%0d idx=%0d required 1 %0d %0d %0d",
                     name, seen, k, steps, step_idx, int'(len) + 3, int'(len) + 1, len);
        end
        next_cycle();
        $display("%s: latency=%0d steps=%0d", name, k, steps);
    endtask

    task automatic test_sw_during_step();
        int bad = 0;
        chain_start = 1; chain_len = 3'd3;
        next_cycle();
        clear_inputs();
        next_cycle();                       // now in first STEP
        for (int i = 0; i < 4; i++) begin
            sw_req = 1; sw_val = 1; alu_req = 1; alu_ov = 1; chain_carry = 0;
            settle();
            if (!(step && sw_stall && alu_stall && grant == 2'b11 && dataIn == 1'b0)) bad++;
            next_cycle();
        end
        clear_inputs();
        settle();
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL sw_during_step: got %0d bad step cycles required 0", bad); end
        n_checks++;
        if (done !== 1'b1 || ovOut !== 1'b0) begin
            n_fail++; $display("FAIL sw_never_written: got done=%b ovOut=%b required 1 0", done, ovOut);
        end
        next_cycle();
        $display("sw_during_step: bad_cycles=%0d ovOut=%b", bad, ovOut);
    endtask

    task automatic test_reset_mid_chain();
        chain_start = 1; chain_len = 3'd3;
        next_cycle();
        clear_inputs();
        next_cycle(); next_cycle();         // step_idx 0 -> 1
        settle();
        n_checks++;
        if (step_idx !== 3'd1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_step: got idx=%0d busy=%b required 1 1", step_idx, busy);
        end
        reset = 1;
        #1;
        n_checks++;
        if ({OvWrite, step, busy, grant, carry_in, step_idx} !== 9'd0) begin
            n_fail++; $display("FAIL reset_mid_chain: got %b required 0", {OvWrite, step, busy, grant, carry_in, step_idx});
        end
        next_cycle();
        reset = 0;
        settle();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got busy=%b done=%b required 0 0", busy, done); end
        next_cycle();
        $display("reset_mid_chain: recovered to idle");
        run_chain(3'd1, "chain_after_reset");
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_priority();
        test_chain_len2();
        run_chain(3'd0, "chain_len0");
        run_chain(3'd7, "chain_len7");
        test_sw_during_step();
        test_reset_mid_chain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
